// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: shared types and constants for the instruction encoder.
//   type_bus_t     - instruction format code carried on in_type
//   INST_R..INST_J - format codes (6 and 7 are undefined and flagged as errors)
//   reg_bus_t      - 32-bit instruction/immediate word
//   OP_*           - base opcodes for the formats the encoder is normally fed
//   enc_entry_t    - one output FIFO entry: {err, inst}
package inst_encoder_pkg;

  localparam int TYPE_W = 3;

  typedef logic [TYPE_W-1:0] type_bus_t;
  typedef logic [31:0]       reg_bus_t;

  localparam type_bus_t INST_R = 3'd0;
  localparam type_bus_t INST_I = 3'd1;
  localparam type_bus_t INST_S = 3'd2;
  localparam type_bus_t INST_B = 3'd3;
  localparam type_bus_t INST_U = 3'd4;
  localparam type_bus_t INST_J = 3'd5;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef struct packed {
    logic     err;
    reg_bus_t inst;
  } enc_entry_t;

  // True when v[31:lo] are all the same bit, i.e. v is representable as a
  // signed value of (lo+1) bits. The arithmetic shift leaves only copies of
  // the sign when that holds.
  function automatic logic upper_uniform(input reg_bus_t v, input int unsigned lo);
    reg_bus_t s;
    s = reg_bus_t'($signed(v) >>> lo);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack: purely combinational packing of a decoded instruction description
// into a 32-bit RISC-V word, with immediate and register range checks.
//   type_i   - format code (INST_R..INST_J)
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i - instruction fields
//   imm_i    - sign-extended immediate (byte offset for B/J, unshifted for U)
//   ent_o    - {err, inst}; inst is forced to zero whenever err is set
module inst_pack
  import inst_encoder_pkg::*;
#(
  parameter int RV32E = 1
) (
  input  type_bus_t  type_i,
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  reg_bus_t   imm_i,
  output enc_entry_t ent_o
);

  reg_bus_t inst;
  logic     bad_imm;
  logic     bad_type;
  logic     bad_reg;
  logic     use_rd;
  logic     use_rs1;
  logic     use_rs2;
  logic     err;

  always_comb begin
    inst     = '0;
    bad_imm  = 1'b0;
    bad_type = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (type_i)
      INST_R: begin
        inst    = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      INST_I: begin
        inst    = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad_imm = !upper_uniform(imm_i, 11);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      INST_S: begin
        inst    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        bad_imm = !upper_uniform(imm_i, 11);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      INST_B: begin
        inst    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        bad_imm = imm_i[0] || !upper_uniform(imm_i, 12);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      INST_U: begin
        inst    = {imm_i[31:12], rd_i, opcode_i};
        bad_imm = (imm_i[11:0] != 12'd0);
        use_rd  = 1'b1;
      end
      INST_J: begin
        inst    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        bad_imm = imm_i[0] || !upper_uniform(imm_i, 20);
        use_rd  = 1'b1;
      end
      default: bad_type = 1'b1;
    endcase
  end

  // RV32E only has x0..x15, so any referenced index with bit 4 set is illegal.
  // Fields the format does not encode are ignored.
  assign bad_reg = (RV32E != 0) &&
                   ((use_rd  && rd_i[4])  ||
                    (use_rs1 && rs1_i[4]) ||
                    (use_rs2 && rs2_i[4]));

  assign err        = bad_imm || bad_type || bad_reg;
  assign ent_o.err  = err;
  assign ent_o.inst = err ? '0 : inst;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32E instruction descriptions into 32-bit words
// and buffers them in a 2-entry FIFO with valid/ready on both sides.
//   clk, rst_n           - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake; fields sampled on accept
//   in_type .. in_imm    - decoded instruction description
//   out_valid / out_ready- result handshake; out_inst/out_err hold while stalled
//   out_inst, out_err    - FIFO head; out_inst is 0 for an erroneous entry
//   err_cnt              - saturating count of accepted erroneous requests
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter int RV32E     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  type_bus_t            in_type,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  reg_bus_t             in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output reg_bus_t             out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  enc_entry_t           pk_ent;
  enc_entry_t           mem_q [2];
  enc_entry_t           head;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 run_q;
  logic                 push;
  logic                 pop;

  inst_pack #(
    .RV32E(RV32E)
  ) u_pack (
    .type_i  (in_type),
    .opcode_i(in_opcode),
    .rd_i    (in_rd),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .funct3_i(in_funct3),
    .funct7_i(in_funct7),
    .imm_i   (in_imm),
    .ent_o   (pk_ent)
  );

  // run_q keeps in_ready low throughout reset without gating on rst_n itself.
  assign in_ready  = run_q && (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is not reset, so the head is masked when the FIFO is empty.
  assign head     = mem_q[rd_ptr_q];
  assign out_inst = out_valid ? head.inst : '0;
  assign out_err  = out_valid && head.err;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push && pk_ent.err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      run_q     <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pk_ent;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;

  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [6:0] O_LUI = 7'b0110111;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_OP  = 7'b0110011;

  typedef struct {
    logic [2:0]  ty;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int ec       = 0;

  inst_encoder #(
    .ERR_CNT_W(8),
    .RV32E    (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_type  (in_type),
    .in_opcode(in_opcode),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_err  (out_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] ty, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp, input logic err);
    vec_t v;
    v.ty = ty; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_type   = v.ty;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  // Presents v, waits (bounded) for in_ready, and returns #1 after the accepting edge.
  task automatic send(input vec_t v);
    int n;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) expect_eq("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t v_addi, v_lui, v_jal, v_beq, v_sw;
  vec_t vb [5];
  vec_t tbl [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v_addi = mk(T_I, O_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    v_lui  = mk(T_U, O_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    v_jal  = mk(T_J, O_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0008, 32'h0080_00EF, 1'b0);
    v_beq  = mk(T_B, O_BR,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    v_sw   = mk(T_S, O_ST,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0);
    vb[0] = v_lui; vb[1] = v_jal; vb[2] = v_beq; vb[3] = v_sw; vb[4] = v_addi;

    // addi imm=2048: out of 12-bit signed range
    tbl[0] = mk(T_I, O_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0, 1'b1);
    // beq with odd offset 3
    tbl[1] = mk(T_B, O_BR,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0, 1'b1);
    // lui with nonzero low 12 bits
    tbl[2] = mk(T_U, O_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0, 1'b1);
    // rd=x16 is not an RV32E register
    tbl[3] = mk(T_I, O_IMM, 5'd16, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 32'h0, 1'b1);
    // add x3,x1,x2 ; imm must be ignored for R
    tbl[4] = mk(T_R, O_OP,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    // sub x3,x1,x2
    tbl[5] = mk(T_R, O_OP,  5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'h0, 32'h4020_81B3, 1'b0);
    // addi x1,x0,-2048: most negative legal I immediate
    tbl[6] = mk(T_I, O_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    // undefined format code
    tbl[7] = mk(3'd6,  O_OP,  5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 32'h0, 1'b1);
    // sw with rs2=x17
    tbl[8] = mk(T_S, O_ST,  5'd0, 5'd1, 5'd17, 3'd2, 7'd0, 32'h0000_0008, 32'h0, 1'b1);
    // jal offset 0x100000 exceeds the 21-bit signed range
    tbl[9] = mk(T_J, O_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0, 1'b1);

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(v_addi);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("rst_out_inst", out_inst, 32'd0);
    expect_eq("rst_out_err", {31'd0, out_err}, 32'd0);
    expect_eq("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    expect_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
    expect_eq("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Single addi, 1-cycle latency
    out_ready = 1'b1;
    send(v_addi);
    @(negedge clk);
    expect_eq("addi_valid", {31'd0, out_valid}, 32'd1);
    expect_eq("addi_inst", out_inst, v_addi.exp);
    expect_eq("addi_err", {31'd0, out_err}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready=1
    for (int k = 0; k < 5; k++) begin
      drive(vb[k]);
      in_valid = 1'b1;
      @(negedge clk);
      expect_eq($sformatf("b2b_ready%0d", k), {31'd0, in_ready}, 32'd1);
      if (k > 0) expect_eq($sformatf("b2b_inst%0d", k - 1), out_inst, vb[k-1].exp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    expect_eq("b2b_inst4", out_inst, vb[4].exp);
    @(posedge clk);
    #1;
    @(negedge clk);
    expect_eq("b2b_drained", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: two accepted, third held off until space frees
    out_ready = 1'b0;
    send(v_lui);
    send(v_jal);
    drive(v_beq);
    in_valid = 1'b1;
    @(negedge clk);
    expect_eq("bp_full_ready", {31'd0, in_ready}, 32'd0);
    expect_eq("bp_head0", out_inst, v_lui.exp);
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_eq("bp_head_hold", out_inst, v_lui.exp);
    expect_eq("bp_still_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    expect_eq("bp_head_pre", out_inst, v_lui.exp);
    @(posedge clk);
    #1;
    @(negedge clk);
    expect_eq("bp_second", out_inst, v_jal.exp);
    expect_eq("bp_ready_again", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    expect_eq("bp_third", out_inst, v_beq.exp);
    expect_eq("bp_third_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    expect_eq("bp_drained", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Range checks and further encodings
    for (int k = 0; k < 10; k++) begin
      send(tbl[k]);
      if (tbl[k].err) ec++;
      @(negedge clk);
      expect_eq($sformatf("tbl%0d_inst", k), out_inst, tbl[k].exp);
      expect_eq($sformatf("tbl%0d_err", k), {31'd0, out_err}, {31'd0, tbl[k].err});
      expect_eq($sformatf("tbl%0d_errcnt", k), {24'd0, err_cnt}, ec);
      @(posedge clk);
      #1;
    end

    // Saturation of err_cnt: one erroneous accept per cycle
    drive(tbl[0]);
    in_valid = 1'b1;
    repeat (254 - ec) @(posedge clk);
    @(negedge clk);
    expect_eq("sat_254", {24'd0, err_cnt}, 32'd254);
    @(posedge clk);
    @(negedge clk);
    expect_eq("sat_255", {24'd0, err_cnt}, 32'd255);
    repeat (20) @(posedge clk);
    @(negedge clk);
    expect_eq("sat_hold", {24'd0, err_cnt}, 32'd255);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset with two buffered entries
    out_ready = 1'b0;
    send(v_addi);
    send(v_lui);
    @(negedge clk);
    expect_eq("mid_valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_eq("mid_valid_async", {31'd0, out_valid}, 32'd0);
    expect_eq("mid_errcnt_async", {24'd0, err_cnt}, 32'd0);
    expect_eq("mid_ready_async", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_eq("post_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("post_ready", {31'd0, in_ready}, 32'd1);
    expect_eq("post_errcnt", {24'd0, err_cnt}, 32'd0);
    out_ready = 1'b1;
    send(v_jal);
    @(negedge clk);
    expect_eq("post_fresh_inst", out_inst, v_jal.exp);
    @(posedge clk);
    #1;
    @(negedge clk);
    expect_eq("post_empty", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
